ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter AW, default 8, program-counter and instruction-address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 Parameter FS_ADD, default 5'b00010, function-select code driven for add-immediate.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  AW  fetch address, equal to pc.
REQ-008 imem_ack  input  1  fetch data valid this cycle.
REQ-009 imem_rdata  input  16  instruction word.
REQ-010 fs  output  5  function select to the function unit.
REQ-011 psw  input  4  function-unit flags {Z,N,C,V}.
REQ-012 ra, rb, rd  output  3 each  source A, source B and destination register indices.
REQ-013 b_sel  output  1  operand-B source: 1 selects imm, 0 selects the register.
REQ-014 imm  output  16  sign-extended imm8.
REQ-015 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-016 pc  output  AW  current program counter.
REQ-017 halted  output  1  sequencer stopped.

Function
REQ-018 Instruction classes SHALL decode from instr[15:14]:
- 00 R-type: fs=instr[13:9], rd=[8:6], ra=[5:3], rb=[2:0].
- 01 I-type add: rd=[13:11], ra=[10:8], imm8=[7:0], fs=FS_ADD, b_sel=1.
- 10 branch: cond=[13:11], off8=[7:0] signed.
- 11 system: [13:12]=00 is HALT; any other value is illegal.
REQ-019 States SHALL be FETCH, DECODE, EXEC, BRANCH, HALT; TRAP exists only per REQ-033.
REQ-020 FETCH: imem_req=1; on imem_ack, latch imem_rdata into the instruction register and go to DECODE; with no ack, remain in FETCH.
REQ-021 imem_ack SHALL be ignored outside FETCH.
REQ-022 DECODE: one cycle; next state is EXEC for R/I-type, BRANCH for branch, HALT for HALT.
REQ-023 EXEC: one cycle driving fs, ra, rb, rd, b_sel and imm; rf_we=1.
REQ-024 EXEC: latch psw into an internal flag register, set pc=pc+1, return to FETCH.
REQ-025 Outside EXEC, rf_we SHALL be 0 and fs SHALL be 0.
REQ-026 BRANCH: one cycle; taken iff the condition holds on the latched flags, not live psw.
REQ-027 Branch conditions: 000 always; 001 Z; 010 !Z; 011 N; 100 C; 101 V; 110 !N; 111 never.
REQ-028 Branch target: taken sets pc=pc+1+sext(off8); not taken sets pc=pc+1; next state is FETCH.
REQ-029 All PC arithmetic SHALL be modulo 2^AW, with silent wrap.
REQ-030 HALT: halted=1 and imem_req=0; the state is left only by reset.
REQ-031 Minimum latency: 3 cycles per instruction when ack arrives in the first FETCH cycle, plus one cycle per wait cycle.

Reset
REQ-032 While rst_n=0, asynchronously force:
- state=FETCH, pc=RESET_PC, flags=0, instruction register=0;
- imem_req=0, rf_we=0, fs=0, b_sel=0, imm=0, ra=rb=rd=0, halted=0.
- After rst_n deasserts, imem_req SHALL go high on the first rising edge.
- A reset during any state, including mid-fetch, SHALL abandon the instruction with no rf_we pulse.

Configuration
REQ-033 Macro CTRL_SEQ_TRAP_EN controls illegal-instruction handling:
- Defined: adds output trap (1 bit), a TRAP state, and decode of cond=111 as illegal.
- An illegal instruction or cond=111 goes from DECODE to TRAP, holding trap=1, imem_req=0 and pc unchanged until reset.
- Not defined: no trap port; illegal system instructions act as NOP (pc=pc+1, no rf_we), and cond=111 is never taken.

Verification
REQ-034 Reset with RESET_PC=8'h10, fetch R-type 16'h0453, ack immediately ->
- fs=5'b00010, rd=1, ra=2, rb=3, rf_we pulse in the 3rd cycle;
- pc=8'h11 after.
REQ-035 I-type 16'h5AFF (rd=3, ra=2, imm8=FF) -> imm=16'hFFFF, b_sel=1, fs=FS_ADD.
REQ-036 Hold imem_ack=0 for 4 cycles, then 1 -> imem_req high for 5 cycles, no early decode, pc stable.
REQ-037 Branch and reset cases:
- EXEC with psw=4'b1000, then branch cond=001, off8=8'hFE at pc=8'h20 -> pc=8'h1F.
- The same branch with Z latched 0 -> pc=8'h21.
- pc=8'hFF with a not-taken branch -> pc=8'h00.
REQ-038 HALT 16'hC000 -> halted=1, imem_req=0 indefinitely; rst_n pulse mid-HALT -> FETCH at RESET_PC.
REQ-039 With CTRL_SEQ_TRAP_EN, 16'hF000 -> trap=1, pc unchanged; without it -> pc increments, no rf_we.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction sequencer (fetch/decode/exec/branch/halt).
// Optional macro CTRL_SEQ_TRAP_EN adds a trap output and TRAP state for illegal encodings.
module ctrl_seq #(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [4:0]     FS_ADD   = 5'b00010
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic [4:0]    fs,
    input  logic [3:0]    psw,
    output logic [2:0]    ra,
    output logic [2:0]    rb,
    output logic [2:0]    rd,
    output logic          b_sel,
    output logic [15:0]   imm,
    output logic          rf_we,
    output logic [AW-1:0] pc,
    output logic          halted
`ifdef CTRL_SEQ_TRAP_EN
    ,
    output logic          trap
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_BRANCH,
        S_HALT
`ifdef CTRL_SEQ_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t        state_q;
    logic [15:0]   ir_q;
    logic [3:0]    flags_q;
    logic [AW-1:0] pc_q;
    logic          imem_req_q, rf_we_q, b_sel_q, halted_q;
    logic [4:0]    fs_q;
    logic [2:0]    ra_q, rb_q, rd_q;
    logic [15:0]   imm_q;
`ifdef CTRL_SEQ_TRAP_EN
    logic          trap_q;
`endif

    logic [AW-1:0] pc_inc_d, br_pc_d, off_ext;
    logic          taken_d;

    // Branches test the flags captured by the last EXEC, never the live psw.
    always_comb begin
        pc_inc_d = pc_q + AW'(1);
        off_ext  = AW'($signed(ir_q[7:0]));
        br_pc_d  = pc_inc_d + off_ext;
        case (ir_q[13:11])
            3'b000:  taken_d = 1'b1;
            3'b001:  taken_d = flags_q[3];
            3'b010:  taken_d = ~flags_q[3];
            3'b011:  taken_d = flags_q[2];
            3'b100:  taken_d = flags_q[1];
            3'b101:  taken_d = flags_q[0];
            3'b110:  taken_d = ~flags_q[2];
            default: taken_d = 1'b0;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values; the async reset clears them together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            flags_q    <= '0;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            fs_q       <= '0;
            b_sel_q    <= 1'b0;
            imm_q      <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            halted_q   <= 1'b0;
`ifdef CTRL_SEQ_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Ack only counts once the request is actually on the bus.
                    if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (ir_q[15:14])
                        2'b00: begin
                            fs_q    <= ir_q[13:9];
                            rd_q    <= ir_q[8:6];
                            ra_q    <= ir_q[5:3];
                            rb_q    <= ir_q[2:0];
                            b_sel_q <= 1'b0;
                            imm_q   <= '0;
                            rf_we_q <= 1'b1;
                            state_q <= S_EXEC;
                        end
                        2'b01: begin
                            fs_q    <= FS_ADD;
                            rd_q    <= ir_q[13:11];
                            ra_q    <= ir_q[10:8];
                            rb_q    <= '0;
                            b_sel_q <= 1'b1;
                            imm_q   <= {{8{ir_q[7]}}, ir_q[7:0]};
                            rf_we_q <= 1'b1;
                            state_q <= S_EXEC;
                        end
                        2'b10: begin
`ifdef CTRL_SEQ_TRAP_EN
                            if (ir_q[13:11] == 3'b111) begin
                                trap_q  <= 1'b1;
                                state_q <= S_TRAP;
                            end else begin
                                state_q <= S_BRANCH;
                            end
`else
                            state_q <= S_BRANCH;
`endif
                        end
                        default: begin
                            if (ir_q[13:12] == 2'b00) begin
                                halted_q <= 1'b1;
                                state_q  <= S_HALT;
                            end else begin
`ifdef CTRL_SEQ_TRAP_EN
                                trap_q     <= 1'b1;
                                state_q    <= S_TRAP;
`else
                                pc_q       <= pc_inc_d;
                                imem_req_q <= 1'b1;
                                state_q    <= S_FETCH;
`endif
                            end
                        end
                    endcase
                end
                S_EXEC: begin
                    flags_q    <= psw;
                    pc_q       <= pc_inc_d;
                    rf_we_q    <= 1'b0;
                    fs_q       <= '0;
                    ra_q       <= '0;
                    rb_q       <= '0;
                    rd_q       <= '0;
                    b_sel_q    <= 1'b0;
                    imm_q      <= '0;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_BRANCH: begin
                    pc_q       <= taken_d ? br_pc_d : pc_inc_d;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
`ifdef CTRL_SEQ_TRAP_EN
                S_TRAP: state_q <= S_TRAP;
`endif
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign fs        = fs_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign rd        = rd_q;
    assign b_sel     = b_sel_q;
    assign imm       = imm_q;
    assign rf_we     = rf_we_q;
    assign halted    = halted_q;
`ifdef CTRL_SEQ_TRAP_EN
    assign trap      = trap_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: vector table for R/I/branch traffic plus hand
// sequences for fetch wait states, illegal encodings, HALT and mid-instruction reset.
module tb_ctrl_seq;

    localparam int          AW       = 8;
    localparam logic [7:0]  RST_PC   = 8'h10;
    localparam logic [4:0]  FSA      = 5'b00010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_rdata = '0;
    logic [4:0]    fs;
    logic [3:0]    psw = '0;
    logic [2:0]    ra, rb, rd;
    logic          b_sel;
    logic [15:0]   imm;
    logic          rf_we;
    logic [AW-1:0] pc;
    logic          halted;
`ifdef CTRL_SEQ_TRAP_EN
    logic          trap;
`endif

    ctrl_seq #(.AW(AW), .RESET_PC(RST_PC), .FS_ADD(FSA)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fs(fs), .psw(psw),
        .ra(ra), .rb(rb), .rd(rd), .b_sel(b_sel), .imm(imm), .rf_we(rf_we),
        .pc(pc), .halted(halted)
`ifdef CTRL_SEQ_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  psw;
        logic [4:0]  fs;
        logic [2:0]  rd, ra, rb;
        logic        b_sel;
        logic [15:0] imm;
        logic        rf_we;
        logic [7:0]  pc_after;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_pc;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Ends at the negedge of the DECODE cycle; optionally stalls ack for `waits` cycles.
    task automatic fetch_instr(input logic [15:0] instr, input int waits);
        int budget = 0;
        while (!imem_req && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("wait_req_high", {31'd0, imem_req}, 32'd1);
            check("wait_pc_stable", {24'd0, pc}, {24'd0, exp_pc});
            check("wait_no_we", {31'd0, rf_we}, 32'd0);
        end
        // NOTE: stimulus changes on the falling edge so the DUT samples settled values.
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        check("decode_no_req", {31'd0, imem_req}, 32'd0);
        check("decode_no_we", {31'd0, rf_we}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int waits, input string tag);
        psw = v.psw;
        fetch_instr(v.instr, waits);
        @(negedge clk);
        check({tag, "_fs"}, {27'd0, fs}, {27'd0, v.fs});
        check({tag, "_rd"}, {29'd0, rd}, {29'd0, v.rd});
        check({tag, "_ra"}, {29'd0, ra}, {29'd0, v.ra});
        check({tag, "_rb"}, {29'd0, rb}, {29'd0, v.rb});
        check({tag, "_bsel"}, {31'd0, b_sel}, {31'd0, v.b_sel});
        check({tag, "_imm"}, {16'd0, imm}, {16'd0, v.imm});
        check({tag, "_we"}, {31'd0, rf_we}, {31'd0, v.rf_we});
        @(negedge clk);
        exp_pc = v.pc_after;
        check({tag, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
        check({tag, "_we_done"}, {31'd0, rf_we}, 32'd0);
        check({tag, "_fs_done"}, {27'd0, fs}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_pc", {24'd0, pc}, {24'd0, RST_PC});
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        exp_pc = RST_PC;
    endtask

    initial begin
        vecs[0]  = '{16'h0453, 4'h0, 5'h02, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 8'h11};
        vecs[1]  = '{16'h5AFF, 4'h8, 5'h02, 3'd3, 3'd2, 3'd0, 1'b1, 16'hFFFF, 1'b1, 8'h12};
        vecs[2]  = '{16'h880C, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h1F};
        vecs[3]  = '{16'h0B7C, 4'h8, 5'h05, 3'd5, 3'd7, 3'd4, 1'b0, 16'h0000, 1'b1, 8'h20};
        vecs[4]  = '{16'h88FE, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h1F};
        vecs[5]  = '{16'h4C05, 4'h0, 5'h02, 3'd1, 3'd4, 3'd0, 1'b1, 16'h0005, 1'b1, 8'h20};
        vecs[6]  = '{16'h88FE, 4'h8, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h21};
        vecs[7]  = '{16'h90DD, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'hFF};
        vecs[8]  = '{16'h9800, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h00};
        vecs[9]  = '{16'h5AFF, 4'h7, 5'h02, 3'd3, 3'd2, 3'd0, 1'b1, 16'hFFFF, 1'b1, 8'h01};
        vecs[10] = '{16'hA010, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h12};
        vecs[11] = '{16'hB005, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h13};
        vecs[12] = '{16'hA880, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h94};
        vecs[13] = '{16'h8000, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h95};

        exp_pc = RST_PC;
        @(negedge clk);
        check("rst_fs", {27'd0, fs}, 32'd0);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_imm", {16'd0, imm}, 32'd0);
        check("rst_bsel", {31'd0, b_sel}, 32'd0);
        do_reset();

        for (int i = 0; i < 14; i++) run_vec(vecs[i], 0, $sformatf("v%0d", i));

        begin
            vec_t w;
            w = '{16'h0453, 4'h0, 5'h02, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 8'h96};
            run_vec(w, 4, "wait4");
        end

`ifdef CTRL_SEQ_TRAP_EN
        fetch_instr(16'hF000, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("trap_ill", {31'd0, trap}, 32'd1);
            check("trap_ill_req", {31'd0, imem_req}, 32'd0);
            check("trap_ill_pc", {24'd0, pc}, {24'd0, exp_pc});
            check("trap_ill_we", {31'd0, rf_we}, 32'd0);
        end
        do_reset();
        check("trap_cleared", {31'd0, trap}, 32'd0);
        fetch_instr(16'hB810, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("trap_c7", {31'd0, trap}, 32'd1);
            check("trap_c7_pc", {24'd0, pc}, {24'd0, exp_pc});
        end
        do_reset();
`else
        begin
            vec_t nop_v, c7_v;
            nop_v = '{16'hF000, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h97};
            c7_v  = '{16'hB810, 4'h0, 5'h00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 8'h98};
            run_vec(nop_v, 0, "ill_nop");
            run_vec(c7_v, 0, "cond7");
        end
`endif

        fetch_instr(16'hC000, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_pc", {24'd0, pc}, {24'd0, exp_pc});
        end
        #2 rst_n = 1'b0;
        #1;
        check("halt_async_rst_pc", {24'd0, pc}, {24'd0, RST_PC});
        check("halt_async_rst_flag", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = RST_PC;
        @(negedge clk);
        check("halt_exit_req", {31'd0, imem_req}, 32'd1);
        run_vec(vecs[0], 0, "after_halt");

        fetch_instr(16'h0B7C, 0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_we", {31'd0, rf_we}, 32'd0);
            check("midrst_pc", {24'd0, pc}, {24'd0, RST_PC});
        end
        rst_n = 1'b1;
        exp_pc = RST_PC;
        @(negedge clk);
        check("midrst_no_we_after", {31'd0, rf_we}, 32'd0);
        check("midrst_req", {31'd0, imem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
